// File: rtl/line_buf_window_ctrl.sv
// rtl/line_buf_window_ctrl.sv - 3x3 window sequencing controller for a 2-line 8-bit shift RAM
module line_buf_window_ctrl #(
  parameter int IMG_W_MAX = 1024,
  parameter int IMG_H_MAX = 1024,
  parameter int DW        = 8,
  localparam int CW       = $clog2(IMG_W_MAX),
  localparam int RW       = $clog2(IMG_H_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pre_frame_vsync,
  input  logic          pre_frame_href,
  input  logic          pre_frame_clken,
  input  logic [DW-1:0] pre_img_y,
  output logic          lb_clken,
  output logic          lb_href,
  output logic [DW-1:0] lb_shiftin,
  input  logic [DW-1:0] lb_taps0x,
  input  logic [DW-1:0] lb_taps1x,
  output logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13,
  output logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23,
  output logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic          post_border,
  output logic [RW-1:0] row_cnt,
  output logic [CW-1:0] col_cnt,
  output logic          err_line_ovf
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_MAX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_MAX - 1);

  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;
  state_t state, state_nxt;

  // vs_q/hr_q serve both as edge detectors and as the first sync delay stage
  logic          vs_q, hr_q;
  logic          vs_rise, hr_rise, hr_fall;
  logic          pix_en, line_full, line_full_cur;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;

  logic          ck_d0;
  logic [DW-1:0] y_d0;
  logic [RW-1:0] row_d0;
  logic [CW-1:0] col_d0;
  logic          win_ok;

  assign vs_rise    = pre_frame_vsync & ~vs_q;
  assign hr_rise    = pre_frame_href & ~hr_q;
  assign hr_fall    = ~pre_frame_href & hr_q;
  assign lb_shiftin = pre_img_y;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, pixel acceptance and line buffer strobes
  always_comb begin
    state_nxt = state;
    if (!pre_frame_vsync) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (vs_rise) state_nxt = hr_rise ? LINE : FRAME;
        FRAME:   if (hr_rise) state_nxt = LINE;
        LINE:    if (!pre_frame_href) state_nxt = FRAME;
        default: state_nxt = IDLE;
      endcase
    end
    // A pixel counts on the cycle the line opens and on the href-fall cycle
    pix_en        = pre_frame_clken & pre_frame_vsync & ((state == LINE) | (state_nxt == LINE));
    line_full_cur = hr_rise ? 1'b0 : line_full;
    col_cur       = hr_rise ? '0 : col_cnt;
    row_cur       = vs_rise ? '0 : row_cnt;
    lb_clken      = pix_en & ~line_full_cur;
    lb_href       = pre_frame_href & (state != IDLE);
  end

  // Sync edge detectors, also the first stage of the sync delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_q <= pre_frame_vsync;
      hr_q <= pre_frame_href;
    end
  end

  // Row/column position, line-full tracking and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt      <= '0;
      col_cnt      <= '0;
      line_full    <= 1'b0;
      err_line_ovf <= 1'b0;
    end else begin
      if (vs_rise) begin
        row_cnt      <= '0;
        err_line_ovf <= 1'b0;
      end
      if (hr_rise) begin
        col_cnt   <= '0;
        line_full <= 1'b0;
      end
      if (lb_clken) begin
        if (col_cur == COL_LAST) begin
          col_cnt      <= COL_LAST;
          line_full    <= 1'b1;
          err_line_ovf <= 1'b1;
        end else begin
          col_cnt <= col_cur + CW'(1);
        end
      end
      // Pixel on the same cycle is counted against the old row above
      if ((state == LINE) && hr_fall && pre_frame_vsync && (row_cnt != ROW_LAST))
        row_cnt <= row_cnt + RW'(1);
    end
  end

  // Stage 1: align live pixel and its position with the line buffer taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_d0  <= 1'b0;
      y_d0   <= '0;
      row_d0 <= '0;
      col_d0 <= '0;
    end else begin
      ck_d0  <= lb_clken;
      y_d0   <= pre_img_y;
      row_d0 <= row_cur;
      col_d0 <= col_cur;
    end
  end

  assign win_ok = ck_d0 & (row_d0 >= RW'(2)) & (col_d0 >= CW'(2));

  // Stage 2: shift a new column into the window and qualify it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_border      <= 1'b0;
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else begin
      post_frame_vsync <= vs_q;
      post_frame_href  <= hr_q;
      post_frame_clken <= win_ok;
      // Centre is one row and one column behind the newest pixel
      post_border      <= win_ok & ((row_d0 == RW'(2)) | (col_d0 == CW'(2)));
      if (ck_d0) begin
        matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= lb_taps1x;
        matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= lb_taps0x;
        matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= y_d0;
      end
    end
  end

endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// tb/tb_line_buf_window_ctrl.sv - directed bench for line_buf_window_ctrl
module tb_line_buf_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0] y = 8'h00;
  logic [7:0] taps0 = 8'h00, taps1 = 8'h00;
  logic       lb_clken, lb_href;
  logic [7:0] lb_shiftin;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic       post_vs, post_hr, post_ck, post_border;
  logic [9:0] row_cnt, col_cnt;
  logic       err_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_buf_window_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ck), .pre_img_y(y),
    .lb_clken(lb_clken), .lb_href(lb_href), .lb_shiftin(lb_shiftin),
    .lb_taps0x(taps0), .lb_taps1x(taps1),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .post_frame_vsync(post_vs), .post_frame_href(post_hr), .post_frame_clken(post_ck),
    .post_border(post_border), .row_cnt(row_cnt), .col_cnt(col_cnt), .err_line_ovf(err_ovf)
  );

  // Ideal 2-line buffer indexed by the column the bench is driving
  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  int tb_col = 0;
  initial for (int i = 0; i < 1024; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
  always @(posedge clk) begin
    if (lb_clken && tb_col < 1024) begin
      taps0 <= mem0[tb_col];
      taps1 <= mem1[tb_col];
      mem1[tb_col] <= mem0[tb_col];
      mem0[tb_col] <= y;
    end
  end

  // Expected 2-cycle delayed sync/strobe history
  logic       cur_exp = 1'b0;
  logic [1:0] vs_h, hr_h, ex_h;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_h <= 2'b00; hr_h <= 2'b00; ex_h <= 2'b00;
    end else begin
      vs_h <= {vs_h[0], vs}; hr_h <= {hr_h[0], hr}; ex_h <= {ex_h[0], cur_exp};
    end
  end

  int sync_mm = 0, clk_mm = 0;
  logic [71:0] win_q[$];
  logic        bord_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (post_vs !== vs_h[1] || post_hr !== hr_h[1]) sync_mm++;
      if (post_ck !== ex_h[1]) clk_mm++;
      if (post_ck === 1'b1) begin
        win_q.push_back({p11, p12, p13, p21, p22, p23, p31, p32, p33});
        bord_q.push_back(post_border);
      end
    end
  end

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], 8'((r - 2 + i) * 16 + (c - 2 + j))};
    return w;
  endfunction

  task automatic cyc(input logic v, input logic h, input logic c, input logic [7:0] yy,
                     input int col, input logic e);
    vs = v; hr = h; ck = c; y = yy; tb_col = col; cur_exp = e;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int rows, input int cols, input logic toggle);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        cyc(1, 1, 1, 8'(r * 16 + c), c, (r >= 2 && c >= 2));
        if (toggle) cyc(1, 1, 0, 0, c, 0);
      end
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_4x4(input string tag);
    int er[4] = '{2, 2, 3, 3};
    int ec[4] = '{2, 3, 2, 3};
    logic eb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [71:0] got;
    logic gb;
    checks++;
    if (win_q.size() !== 4) begin
      failures++; $display("FAIL %s win_count got=%0d exp=4", tag, win_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < win_q.size()) ? win_q[k] : 'x;
      gb  = (k < bord_q.size()) ? bord_q[k] : 1'bx;
      checks++;
      if (got !== exp_win(er[k], ec[k])) begin
        failures++; $display("FAIL %s window%0d got=%h exp=%h", tag, k, got, exp_win(er[k], ec[k]));
      end
      checks++;
      if (gb !== eb[k]) begin
        failures++; $display("FAIL %s border%0d got=%b exp=%b", tag, k, gb, eb[k]);
      end
    end
    checks++;
    if (clk_mm !== 0) begin
      failures++; $display("FAIL %s strobe_timing mismatches=%0d exp=0", tag, clk_mm);
    end
    checks++;
    if (sync_mm !== 0) begin
      failures++; $display("FAIL %s sync_delay mismatches=%0d exp=0", tag, sync_mm);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lb_clken, lb_href, lb_shiftin} !== 10'd0) begin
      failures++; $display("FAIL reset_lb got=%b exp=0", {lb_clken, lb_href, lb_shiftin});
    end
    checks++;
    if ({post_vs, post_hr, post_ck, post_border, err_ovf} !== 5'd0) begin
      failures++; $display("FAIL reset_post got=%b exp=0", {post_vs, post_hr, post_ck, post_border, err_ovf});
    end
    checks++;
    if ({row_cnt, col_cnt} !== 20'd0) begin
      failures++; $display("FAIL reset_cnt row=%0d col=%0d exp=0", row_cnt, col_cnt);
    end
    checks++;
    if ({p11, p12, p13, p21, p22, p23, p31, p32, p33} !== 72'd0) begin
      failures++; $display("FAIL reset_matrix got=%h exp=0", {p11, p12, p13, p21, p22, p23, p31, p32, p33});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame_4x4;
    win_q.delete(); bord_q.delete(); clk_mm = 0; sync_mm = 0;
    send_frame(4, 4, 1'b0);
    check_4x4("frame4x4");
    checks++;
    if (row_cnt !== 10'd4 || col_cnt !== 10'd4) begin
      failures++; $display("FAIL frame4x4_counters row=%0d col=%0d exp=4/4", row_cnt, col_cnt);
    end
  endtask

  task automatic test_toggle;
    win_q.delete(); bord_q.delete(); clk_mm = 0; sync_mm = 0;
    send_frame(4, 4, 1'b1);
    check_4x4("toggle");
  endtask

  task automatic test_overflow;
    int bad;
    bad = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 1030; k++) begin
      vs = 1; hr = 1; ck = 1; y = 8'(k); tb_col = k; cur_exp = 0;
      #1;
      if (lb_clken !== (k < 1024)) bad++;
      if (k == 1023) begin
        checks++;
        if (err_ovf !== 1'b0) begin
          failures++; $display("FAIL ovf_before_1023 got=%b exp=0", err_ovf);
        end
      end
      @(posedge clk); #1;
      if (k == 1023) begin
        checks++;
        if (err_ovf !== 1'b1 || col_cnt !== 10'd1023) begin
          failures++; $display("FAIL ovf_at_1023 err=%b col=%0d exp=1/1023", err_ovf, col_cnt);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL ovf_lb_clken mismatches=%0d exp=0", bad);
    end
    checks++;
    if (col_cnt !== 10'd1023) begin
      failures++; $display("FAIL ovf_col_hold got=%0d exp=1023", col_cnt);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b exp=1", err_ovf);
    end
    cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear_on_vsync got=%b exp=0", err_ovf);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midline;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) cyc(1, 1, 1, 8'(r * 16 + c), c, (r >= 2 && c >= 2));
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    for (int c = 0; c < 5; c++) cyc(1, 1, 1, 8'(48 + c), c, 1'b1);
    checks++;
    if (row_cnt !== 10'd3 || col_cnt !== 10'd5) begin
      failures++; $display("FAIL midline_position row=%0d col=%0d exp=3/5", row_cnt, col_cnt);
    end
    #2;
    ck = 0; y = 8'h00; cur_exp = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({post_vs, post_hr, post_ck, post_border, err_ovf, lb_clken, lb_href} !== 7'd0) begin
      failures++; $display("FAIL midline_async_outputs got=%b exp=0",
                           {post_vs, post_hr, post_ck, post_border, err_ovf, lb_clken, lb_href});
    end
    checks++;
    if ({row_cnt, col_cnt} !== 20'd0 || {p11, p12, p13, p21, p22, p23, p31, p32, p33} !== 72'd0) begin
      failures++; $display("FAIL midline_async_state row=%0d col=%0d matrix=%h exp=0", row_cnt, col_cnt,
                           {p11, p12, p13, p21, p22, p23, p31, p32, p33});
    end
    @(posedge clk); #1;
    vs = 0; hr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    win_q.delete(); bord_q.delete(); clk_mm = 0; sync_mm = 0;
    send_frame(4, 4, 1'b0);
    check_4x4("after_reset");
  endtask

  task automatic test_vsync_fall;
    int bad;
    int n0;
    bad = 0;
    win_q.delete(); bord_q.delete(); clk_mm = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) cyc(1, 1, 1, 8'(r * 16 + c), c, (r >= 2 && c >= 2));
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    cyc(1, 1, 1, 8'h30, 0, 0);
    cyc(1, 1, 1, 8'h31, 1, 0);
    n0 = win_q.size();
    checks++;
    if (n0 !== 2) begin
      failures++; $display("FAIL vfall_prior_windows got=%0d exp=2", n0);
    end
    for (int i = 0; i < 4; i++) begin
      vs = 0; hr = 1; ck = 1; y = 8'(50 + i); tb_col = 2 + i; cur_exp = 0;
      #1;
      if (lb_clken !== 1'b0) bad++;
      if (i > 0 && lb_href !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL vfall_idle_drive mismatches=%0d exp=0", bad);
    end
    checks++;
    if (row_cnt !== 10'd3) begin
      failures++; $display("FAIL vfall_row_cnt got=%0d exp=3", row_cnt);
    end
    checks++;
    if (win_q.size() !== n0 || clk_mm !== 0) begin
      failures++; $display("FAIL vfall_no_strobes windows=%0d exp=%0d timing_mm=%0d", win_q.size(), n0, clk_mm);
    end
  endtask

  task automatic test_short_frames;
    win_q.delete(); bord_q.delete(); clk_mm = 0; sync_mm = 0;
    send_frame(1, 4, 1'b0);
    send_frame(2, 4, 1'b0);
    checks++;
    if (win_q.size() !== 0) begin
      failures++; $display("FAIL short_frames windows got=%0d exp=0", win_q.size());
    end
    checks++;
    if (sync_mm !== 0 || clk_mm !== 0) begin
      failures++; $display("FAIL short_frames delay sync_mm=%0d clk_mm=%0d exp=0", sync_mm, clk_mm);
    end
  endtask

  initial begin
    test_reset();
    test_frame_4x4();
    test_toggle();
    test_overflow();
    test_reset_midline();
    test_vsync_fall();
    test_short_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
